// File: rtl/adc_sample_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : adc_sample_ctrl
// Purpose  : Periodic sequencer for a 16-bit SPI ADC master. Fires a start
//            pulse every SAMPLE_PERIOD cycles. Detects end of transfer when
//            chip select returns high. Averages 2^AVG_LOG2 results and
//            offers the average on a valid/ready handshake. Overrun and
//            timeout are reported on sticky flags.
// Ports    : clk, rst_n            clock, asynchronous active-low reset
//            enable                periodic sampling enable
//            spi_start             one-cycle start pulse to the SPI master
//            spi_cs_n, spi_data    chip select and result from the master
//            sample_data/valid     averaged sample, valid flag
//            sample_ready          downstream accept
//            overrun, timeout_err  sticky error flags
//            clear_err             synchronous clear of both flags
// Revision : 1.0 - initial release
// ============================================================================
module adc_sample_ctrl #(
  parameter int SAMPLE_PERIOD = 1000,
  parameter int AVG_LOG2      = 2,
  parameter int TIMEOUT       = 2048
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  output logic        spi_start,
  input  logic        spi_cs_n,
  input  logic [15:0] spi_data,
  output logic [15:0] sample_data,
  output logic        sample_valid,
  input  logic        sample_ready,
  output logic        overrun,
  output logic        timeout_err,
  input  logic        clear_err
);

  localparam int ACC_W  = 16 + AVG_LOG2;
  localparam int CNT_W  = AVG_LOG2 + 1;
  localparam int PCNT_W = $clog2(SAMPLE_PERIOD);
  localparam int TCNT_W = $clog2(TIMEOUT + 1);

  localparam logic [PCNT_W-1:0] PCNT_LAST = PCNT_W'(SAMPLE_PERIOD - 1);
  localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'((1 << AVG_LOG2) - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_WAIT_LOW  = 3'd2,
    S_WAIT_HIGH = 3'd3,
    S_CAPTURE   = 3'd4
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [PCNT_W-1:0]   pcnt;
  logic [TCNT_W-1:0]   tcnt;
  logic [ACC_W-1:0]    acc;
  logic [CNT_W-1:0]    cnt;
  logic                trigger;
  logic                tmo_hit;
  logic [ACC_W-1:0]    sum;
  logic [15:0]         result;
  logic                result_rdy;

  assign trigger    = enable && (pcnt == PCNT_LAST);
  assign sum        = acc + ACC_W'(spi_data);
  assign result     = 16'(sum >> AVG_LOG2);
  assign result_rdy = (state == S_CAPTURE) && (cnt == CNT_LAST);

  // Period counter free-runs while enabled, independent of the FSM, so a
  // trigger landing on a busy FSM is simply lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcnt <= '0;
    end else if (!enable || pcnt == PCNT_LAST) begin
      pcnt <= '0;
    end else begin
      pcnt <= pcnt + PCNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Completion in WAIT_HIGH wins over the timeout, so a transfer ending
  // exactly on the limit is still accepted.
  always_comb begin
    state_nxt = state;
    spi_start = 1'b0;
    tmo_hit   = 1'b0;
    case (state)
      S_IDLE: begin
        if (trigger) state_nxt = S_START;
      end
      S_START: begin
        spi_start = 1'b1;
        state_nxt = S_WAIT_LOW;
      end
      S_WAIT_LOW: begin
        if (tcnt == TCNT_LAST) begin
          tmo_hit   = 1'b1;
          state_nxt = S_IDLE;
        end else if (!spi_cs_n) begin
          state_nxt = S_WAIT_HIGH;
        end
      end
      S_WAIT_HIGH: begin
        if (spi_cs_n) begin
          state_nxt = S_CAPTURE;
        end else if (tcnt == TCNT_LAST) begin
          tmo_hit   = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      S_CAPTURE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tcnt <= '0;
    end else if (state == S_START) begin
      tcnt <= '0;
    end else if (state == S_WAIT_LOW || state == S_WAIT_HIGH) begin
      tcnt <= tcnt + TCNT_W'(1);
    end
  end

  // Accumulator is wide enough for 2^AVG_LOG2 full-scale samples. A partial
  // average is dropped whenever the sequencer parks with enable low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
      cnt <= '0;
    end else if (state == S_CAPTURE) begin
      if (cnt == CNT_LAST) begin
        acc <= '0;
        cnt <= '0;
      end else begin
        acc <= sum;
        cnt <= cnt + CNT_W'(1);
      end
    end else if (state == S_IDLE && !enable) begin
      acc <= '0;
      cnt <= '0;
    end
  end

  // Single-entry output register. A new result may replace the old one in
  // the very cycle the old one is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample_data  <= '0;
      sample_valid <= 1'b0;
    end else if (result_rdy && (!sample_valid || sample_ready)) begin
      sample_data  <= result;
      sample_valid <= 1'b1;
    end else if (sample_valid && sample_ready) begin
      sample_valid <= 1'b0;
    end
  end

  // Set events take priority over clear_err.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun     <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      if (result_rdy && sample_valid && !sample_ready) begin
        overrun <= 1'b1;
      end else if (clear_err) begin
        overrun <= 1'b0;
      end
      if (tmo_hit) begin
        timeout_err <= 1'b1;
      end else if (clear_err) begin
        timeout_err <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_adc_sample_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_adc_sample_ctrl
// Purpose  : Self-checking bench for adc_sample_ctrl. One instance averages
//            four samples; a second instance runs in passthrough mode. Each
//            instance has a behavioural SPI master model. Expected samples
//            are queued as stimulus is issued and popped on every accepted
//            output.
// Revision : 1.0 - initial release
// ============================================================================
module tb_adc_sample_ctrl;

  localparam int PER = 200;
  localparam int TMO = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  // averaging instance
  logic        enable, spi_start, spi_cs_n, sample_valid, sample_ready;
  logic        overrun, timeout_err, clear_err;
  logic [15:0] spi_data, sample_data;
  // passthrough instance
  logic        enable0, spi_start0, spi_cs_n0, sample_valid0, sample_ready0;
  logic        overrun0, timeout_err0, clear_err0;
  logic [15:0] spi_data0, sample_data0;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [15:0] spi_vals[$];
  logic [15:0] exp_q[$];
  logic [15:0] exp_v;
  int          done_cnt = 0;
  int          acc_cnt  = 0;
  bit          hang     = 1'b0;

  int          exp0_cyc[$];
  int          exp0_c;
  int          acc0_cnt = 0;

  adc_sample_ctrl #(.SAMPLE_PERIOD(PER), .AVG_LOG2(2), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .spi_start(spi_start),
    .spi_cs_n(spi_cs_n), .spi_data(spi_data), .sample_data(sample_data),
    .sample_valid(sample_valid), .sample_ready(sample_ready),
    .overrun(overrun), .timeout_err(timeout_err), .clear_err(clear_err)
  );

  adc_sample_ctrl #(.SAMPLE_PERIOD(PER), .AVG_LOG2(0), .TIMEOUT(TMO)) dut0 (
    .clk(clk), .rst_n(rst_n), .enable(enable0), .spi_start(spi_start0),
    .spi_cs_n(spi_cs_n0), .spi_data(spi_data0), .sample_data(sample_data0),
    .sample_valid(sample_valid0), .sample_ready(sample_ready0),
    .overrun(overrun0), .timeout_err(timeout_err0), .clear_err(clear_err0)
  );

  always @(posedge clk) cyc++;

  // SPI master model for the averaging instance: cs_n low for 16 cycles,
  // result presented as cs_n returns high.
  initial begin
    spi_cs_n = 1'b1;
    spi_data = 16'h0;
    forever begin
      @(negedge clk);
      if (spi_start === 1'b1 && !hang) begin
        @(negedge clk);
        spi_cs_n = 1'b0;
        repeat (16) @(negedge clk);
        if (spi_vals.size() > 0) spi_data = spi_vals.pop_front();
        else spi_data = 16'h0;
        spi_cs_n = 1'b1;
        done_cnt++;
      end
    end
  end

  // SPI master model for the passthrough instance; the valid is expected two
  // cycles after cs_n returns high.
  initial begin
    spi_cs_n0 = 1'b1;
    spi_data0 = 16'h0;
    forever begin
      @(negedge clk);
      if (spi_start0 === 1'b1) begin
        @(negedge clk);
        spi_cs_n0 = 1'b0;
        repeat (16) @(negedge clk);
        spi_data0 = 16'hF0A5;
        spi_cs_n0 = 1'b1;
        exp0_cyc.push_back(cyc + 2);
      end
    end
  end

  // Scoreboard: every accepted sample must match the head of the queue.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && sample_valid === 1'b1 && sample_ready === 1'b1) begin
      acc_cnt++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: got %h, required no sample", sample_data);
      end else begin
        exp_v = exp_q.pop_front();
        if (sample_data !== exp_v) begin
          errors++;
          $display("FAIL sb_data: got %h, required %h", sample_data, exp_v);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n === 1'b1 && sample_valid0 === 1'b1) begin
      acc0_cnt++;
      checks++;
      if (exp0_cyc.size() == 0) begin
        errors++;
        $display("FAIL pt_unexpected: got %h, required no sample", sample_data0);
      end else begin
        exp0_c = exp0_cyc.pop_front();
        if (sample_data0 !== 16'hF0A5 || cyc != exp0_c) begin
          errors++;
          $display("FAIL pt_sample: got %h at cycle %0d, required f0a5 at cycle %0d",
                   sample_data0, cyc, exp0_c);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Inputs change just after a rising edge, clear of the negedge samplers.
  task automatic drive_point();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int n, input int budget);
    int target;
    int k;
    target = done_cnt + n;
    k = 0;
    while (done_cnt < target && k < budget) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (done_cnt < target) begin
      errors++;
      $display("FAIL xfer_wait: got %0d transfers, required %0d", done_cnt, target);
    end
  endtask

  task automatic stop_sampling();
    drive_point();
    enable = 1'b0;
    tick(40);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    enable = 1'b0; enable0 = 1'b0;
    sample_ready = 1'b1; sample_ready0 = 1'b1;
    clear_err = 1'b0; clear_err0 = 1'b0;
    tick(3);
    checks++;
    if ({spi_start, sample_valid, sample_data, overrun, timeout_err} !== 20'h0) begin
      errors++;
      $display("FAIL reset_outputs: got %h, required 0",
               {spi_start, sample_valid, sample_data, overrun, timeout_err});
    end
    checks++;
    if ({spi_start0, sample_valid0, sample_data0, overrun0, timeout_err0} !== 20'h0) begin
      errors++;
      $display("FAIL reset_outputs_pt: got %h, required 0",
               {spi_start0, sample_valid0, sample_data0, overrun0, timeout_err0});
    end
    drive_point();
    rst_n = 1'b1;
    tick(2);
  endtask

  task automatic test_passthrough();
    int starts[$];
    int e;
    bit prev;
    prev = 1'b0;
    drive_point();
    enable0 = 1'b1;
    e = cyc;
    for (int i = 0; i < 3 * PER + 30; i++) begin
      @(negedge clk);
      if (spi_start0 === 1'b1) begin
        starts.push_back(cyc);
        checks++;
        if (prev) begin
          errors++;
          $display("FAIL start_width: got start high on consecutive cycles, required 1");
        end
      end
      prev = spi_start0;
    end
    checks++;
    if (starts.size() != 3) begin
      errors++;
      $display("FAIL start_count: got %0d, required 3", starts.size());
    end
    if (starts.size() > 0) begin
      checks++;
      if (starts[0] != e + PER) begin
        errors++;
        $display("FAIL first_start: got cycle %0d, required %0d", starts[0], e + PER);
      end
    end
    for (int i = 1; i < starts.size(); i++) begin
      checks++;
      if (starts[i] - starts[i-1] != PER) begin
        errors++;
        $display("FAIL start_period: got %0d, required %0d", starts[i] - starts[i-1], PER);
      end
    end
    drive_point();
    enable0 = 1'b0;
    tick(40);
    checks++;
    if (acc0_cnt != 3 || exp0_cyc.size() != 0) begin
      errors++;
      $display("FAIL pt_count: got %0d valids (%0d pending), required 3 (0)",
               acc0_cnt, exp0_cyc.size());
    end
  endtask

  task automatic test_average();
    int base;
    base = acc_cnt;
    spi_vals.push_back(16'h0001); spi_vals.push_back(16'h0002);
    spi_vals.push_back(16'h0003); spi_vals.push_back(16'h0004);
    exp_q.push_back(16'h0002);
    drive_point();
    enable = 1'b1;
    wait_done(3, 3 * PER + 50);
    tick(5);
    checks++;
    if (acc_cnt != base) begin
      errors++;
      $display("FAIL avg_early: got %0d outputs, required 0", acc_cnt - base);
    end
    wait_done(1, PER + 50);
    tick(5);
    checks++;
    if (acc_cnt != base + 1) begin
      errors++;
      $display("FAIL avg_count: got %0d outputs, required 1", acc_cnt - base);
    end
    stop_sampling();
  endtask

  task automatic test_full_scale();
    int base;
    base = acc_cnt;
    repeat (4) spi_vals.push_back(16'hFFFF);
    repeat (4) spi_vals.push_back(16'h0000);
    exp_q.push_back(16'hFFFF);
    exp_q.push_back(16'h0000);
    drive_point();
    enable = 1'b1;
    wait_done(8, 8 * PER + 50);
    tick(5);
    stop_sampling();
    checks++;
    if (acc_cnt != base + 2 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL full_scale_count: got %0d outputs, required 2", acc_cnt - base);
    end
  endtask

  task automatic test_overrun();
    int base;
    base = acc_cnt;
    drive_point();
    sample_ready = 1'b0;
    repeat (4) spi_vals.push_back(16'h1234);
    repeat (4) spi_vals.push_back(16'h5678);
    exp_q.push_back(16'h1234);
    enable = 1'b1;
    wait_done(8, 8 * PER + 50);
    tick(3);
    stop_sampling();
    checks++;
    if (sample_valid !== 1'b1 || sample_data !== 16'h1234) begin
      errors++;
      $display("FAIL ovr_hold: got valid=%b data=%h, required valid=1 data=1234",
               sample_valid, sample_data);
    end
    checks++;
    if (overrun !== 1'b1) begin
      errors++;
      $display("FAIL ovr_flag: got %b, required 1", overrun);
    end
    drive_point();
    sample_ready = 1'b1;
    tick(2);
    checks++;
    if (sample_valid !== 1'b0 || acc_cnt != base + 1) begin
      errors++;
      $display("FAIL ovr_accept: got valid=%b accepted=%0d, required valid=0 accepted=1",
               sample_valid, acc_cnt - base);
    end
    checks++;
    if (overrun !== 1'b1) begin
      errors++;
      $display("FAIL ovr_sticky: got %b, required 1", overrun);
    end
    drive_point();
    clear_err = 1'b1;
    drive_point();
    clear_err = 1'b0;
    tick(1);
    checks++;
    if (overrun !== 1'b0) begin
      errors++;
      $display("FAIL ovr_clear: got %b, required 0", overrun);
    end
  endtask

  task automatic test_timeout();
    int base;
    int s;
    int t;
    int k;
    base = acc_cnt;
    s = -1;
    t = -1;
    hang = 1'b1;
    drive_point();
    enable = 1'b1;
    k = 0;
    while (s < 0 && k < PER + 20) begin
      @(negedge clk);
      if (spi_start === 1'b1) s = cyc;
      k++;
    end
    checks++;
    if (s < 0) begin
      errors++;
      $display("FAIL tmo_start: got no spi_start, required one");
    end
    k = 0;
    while (t < 0 && k < 200) begin
      @(negedge clk);
      if (timeout_err === 1'b1) t = cyc;
      k++;
    end
    checks++;
    if (s < 0 || t < 0 || t - s < TMO || t - s > TMO + 1) begin
      errors++;
      $display("FAIL tmo_latency: got %0d cycles, required %0d..%0d", t - s, TMO, TMO + 1);
    end
    k = 0;
    s = -1;
    while (s < 0 && k < PER + 20) begin
      @(negedge clk);
      if (spi_start === 1'b1) s = cyc;
      k++;
    end
    checks++;
    if (s < 0) begin
      errors++;
      $display("FAIL tmo_restart: got no spi_start after timeout, required one");
    end
    drive_point();
    enable = 1'b0;
    tick(80);
    checks++;
    if (acc_cnt != base || sample_valid !== 1'b0) begin
      errors++;
      $display("FAIL tmo_novalid: got %0d outputs valid=%b, required 0 outputs valid=0",
               acc_cnt - base, sample_valid);
    end
    drive_point();
    clear_err = 1'b1;
    drive_point();
    clear_err = 1'b0;
    tick(1);
    checks++;
    if (timeout_err !== 1'b0) begin
      errors++;
      $display("FAIL tmo_clear: got %b, required 0", timeout_err);
    end
    hang = 1'b0;
  endtask

  task automatic test_reset_midxfer();
    int base;
    int k;
    drive_point();
    sample_ready = 1'b0;
    repeat (4) spi_vals.push_back(16'h0040);
    repeat (3) spi_vals.push_back(16'h0100);
    enable = 1'b1;
    wait_done(6, 6 * PER + 50);
    tick(3);
    checks++;
    if (sample_valid !== 1'b1 || sample_data !== 16'h0040) begin
      errors++;
      $display("FAIL rst_pending: got valid=%b data=%h, required valid=1 data=0040",
               sample_valid, sample_data);
    end
    k = 0;
    while (spi_cs_n !== 1'b0 && k < PER + 40) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (spi_cs_n !== 1'b0) begin
      errors++;
      $display("FAIL rst_wait_cs: got cs_n=%b, required 0", spi_cs_n);
    end
    tick(5);
    #2;
    rst_n = 1'b0;
    enable = 1'b0;
    #1;
    checks++;
    if ({spi_start, sample_valid, sample_data, overrun, timeout_err} !== 20'h0) begin
      errors++;
      $display("FAIL rst_async: got %h, required 0",
               {spi_start, sample_valid, sample_data, overrun, timeout_err});
    end
    tick(30);
    drive_point();
    rst_n = 1'b1;
    sample_ready = 1'b1;
    spi_vals.delete();
    repeat (4) spi_vals.push_back(16'h0008);
    exp_q.push_back(16'h0008);
    base = acc_cnt;
    drive_point();
    enable = 1'b1;
    wait_done(3, 3 * PER + 50);
    tick(5);
    checks++;
    if (acc_cnt != base) begin
      errors++;
      $display("FAIL rst_early: got %0d outputs, required 0", acc_cnt - base);
    end
    wait_done(1, PER + 50);
    tick(5);
    stop_sampling();
    checks++;
    if (acc_cnt != base + 1 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL rst_after: got %0d outputs, required 1", acc_cnt - base);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    enable = 1'b0; enable0 = 1'b0;
    sample_ready = 1'b1; sample_ready0 = 1'b1;
    clear_err = 1'b0; clear_err0 = 1'b0;
    test_reset();
    test_passthrough();
    test_average();
    test_full_scale();
    test_overrun();
    test_timeout();
    test_reset_midxfer();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
